// File: rtl/pipe_ctrl_rv32.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_rv32
// Pipelined control unit for the 5-stage RV32I core. Decodes in D and carries
// the control bundle through the D->E, E->M and M->W boundaries. Resolves
// branches and jumps in E and flags unsupported encodings in D.
//
// Parameters:
//   ALUCTRL_W  ALUControlE width (>= 4, bits above [3] are always 0)
//   CNT_W      width of the optional performance counters
//
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN
//   Adds BranchTakenCnt / FlushCnt outputs (CNT_W wide, wrapping).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   opD, funct3D, funct7b5D      instruction fields in Decode
//   FlushE                       turns the next E-stage entry into a bubble
//   ZeroE, LtE, LtuE             ALU comparison flags for the E-stage op
//   ImmSrcD, IllegalD            combinational Decode outputs
//   ALUControlE, ALUSrcE, ALUSrcAE, ResultSrcE0, RegWriteE   E-stage control
//   PCSrcE, PCTargetSrcE         fetch redirect and target select
//   RegWriteM, MemWriteM         M-stage control
//   RegWriteW, ResultSrcW        W-stage control
// -----------------------------------------------------------------------------
module pipe_ctrl_rv32 #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 ALUSrcAE,
  output logic                 PCSrcE,
  output logic                 PCTargetSrcE,
  output logic                 ResultSrcE0,
  output logic                 RegWriteE,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcW
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     BranchTakenCnt,
  output logic [CNT_W-1:0]     FlushCnt
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Elaboration-time parameter sanity checks
  if (ALUCTRL_W < 4) begin : gBadAluCtrlW
    $error("pipe_ctrl_rv32: ALUCTRL_W must be at least 4");
  end
  if (CNT_W < 1) begin : gBadCntW
    $error("pipe_ctrl_rv32: CNT_W must be at least 1");
  end

  logic       regWriteD, memWriteD, jumpD, branchD, jalrD, aluSrcD, aluSrcAD;
  logic [1:0] resultSrcD;
  logic [3:0] aluCtrlD, aluArithD;

  logic       jumpE, branchE, jalrE, memWriteE, branchCondE;
  logic [1:0] resultSrcE, resultSrcM;
  logic [3:0] aluCtrlE;
  logic [2:0] funct3E;

  // ALU op shared by R-type and I-ALU. funct7b5 selects sub only for R-type,
  // because in I-ALU form that bit belongs to the immediate.
  always_comb begin
    aluArithD = ALU_ADD;
    case (funct3D)
      3'b000:  aluArithD = (opD == OP_R && funct7b5D) ? ALU_SUB : ALU_ADD;
      3'b001:  aluArithD = ALU_SLL;
      3'b010:  aluArithD = ALU_SLT;
      3'b011:  aluArithD = ALU_SLTU;
      3'b100:  aluArithD = ALU_XOR;
      3'b101:  aluArithD = funct7b5D ? ALU_SRA : ALU_SRL;
      3'b110:  aluArithD = ALU_OR;
      default: aluArithD = ALU_AND;
    endcase
  end

  // Main decoder. Everything defaults to a harmless no-op so that illegal
  // encodings never write, branch or jump.
  always_comb begin
    regWriteD  = 1'b0;
    resultSrcD = 2'b00;
    memWriteD  = 1'b0;
    jumpD      = 1'b0;
    branchD    = 1'b0;
    jalrD      = 1'b0;
    aluSrcD    = 1'b0;
    aluSrcAD   = 1'b0;
    aluCtrlD   = ALU_ADD;
    ImmSrcD    = 3'b000;
    IllegalD   = 1'b0;
    case (opD)
      OP_LOAD: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b01;
        aluSrcD    = 1'b1;
      end
      OP_STORE: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        ImmSrcD   = 3'b001;
      end
      OP_R: begin
        regWriteD = 1'b1;
        aluCtrlD  = aluArithD;
      end
      OP_IALU: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        aluCtrlD  = aluArithD;
      end
      OP_BRANCH: begin
        ImmSrcD  = 3'b010;
        aluCtrlD = ALU_SUB;
        // funct3 010/011 are not branch conditions
        if (funct3D[2:1] == 2'b01) IllegalD = 1'b1;
        else                       branchD  = 1'b1;
      end
      OP_JAL: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b10;
        jumpD      = 1'b1;
        ImmSrcD    = 3'b011;
      end
      OP_JALR: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b10;
        jumpD      = 1'b1;
        jalrD      = 1'b1;
        aluSrcD    = 1'b1;
      end
      OP_LUI: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b11;
        ImmSrcD    = 3'b100;
      end
      OP_AUIPC: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        aluSrcAD  = 1'b1;
        ImmSrcD   = 3'b100;
      end
      default: IllegalD = 1'b1;
    endcase
  end

  // D->E register. A flush loads an all-zero bubble and wins over new decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || FlushE) begin
      RegWriteE  <= 1'b0;
      resultSrcE <= 2'b00;
      memWriteE  <= 1'b0;
      jumpE      <= 1'b0;
      branchE    <= 1'b0;
      jalrE      <= 1'b0;
      aluCtrlE   <= 4'd0;
      ALUSrcE    <= 1'b0;
      ALUSrcAE   <= 1'b0;
      funct3E    <= 3'b000;
    end else begin
      RegWriteE  <= regWriteD;
      resultSrcE <= resultSrcD;
      memWriteE  <= memWriteD;
      jumpE      <= jumpD;
      branchE    <= branchD;
      jalrE      <= jalrD;
      aluCtrlE   <= aluCtrlD;
      ALUSrcE    <= aluSrcD;
      ALUSrcAE   <= aluSrcAD;
      funct3E    <= funct3D;
    end
  end

  // Branch condition from the ALU flags of the op currently in E
  always_comb begin
    branchCondE = 1'b0;
    case (funct3E)
      3'b000:  branchCondE = ZeroE;
      3'b001:  branchCondE = ~ZeroE;
      3'b100:  branchCondE = LtE;
      3'b101:  branchCondE = ~LtE;
      3'b110:  branchCondE = LtuE;
      3'b111:  branchCondE = ~LtuE;
      default: branchCondE = 1'b0;
    endcase
  end

  assign PCSrcE       = jumpE | (branchE & branchCondE);
  assign PCTargetSrcE = jumpE & jalrE;
  assign ResultSrcE0  = resultSrcE[0];
  assign ALUControlE  = ALUCTRL_W'(aluCtrlE);

  // E->M and M->W registers: free-running, only the writeback-relevant bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteM  <= RegWriteE;
      resultSrcM <= resultSrcE;
      MemWriteM  <= memWriteE;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= resultSrcM;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Performance counters: taken redirects and flush requests, wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BranchTakenCnt <= '0;
      FlushCnt       <= '0;
    end else begin
      if (PCSrcE) BranchTakenCnt <= BranchTakenCnt + CNT_W'(1);
      if (FlushE) FlushCnt       <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_rv32.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_rv32
// Self-checking bench for pipe_ctrl_rv32: a vector table for single-op decode
// and E-stage resolution, hand-written multi-cycle sequences for reset, flush
// and illegal ops, then randomized traffic against a queue-based model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_rv32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D, FlushE, ZeroE, LtE, LtuE;
  logic [2:0] ImmSrcD;
  logic       IllegalD, ALUSrcE, ALUSrcAE, PCSrcE, PCTargetSrcE, ResultSrcE0;
  logic       RegWriteE, RegWriteM, RegWriteW, MemWriteM;
  logic [3:0] ALUControlE;
  logic [1:0] ResultSrcW;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [3:0] branchTakenCnt, flushCnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_rv32 #(.ALUCTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE),
    .ResultSrcE0(ResultSrcE0), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemWriteM(MemWriteM), .ResultSrcW(ResultSrcW)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .BranchTakenCnt(branchTakenCnt), .FlushCnt(flushCnt)
`endif
  );

  // Expected control bundle of one instruction, in architectural terms
  typedef struct {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       aluSrc;
    logic       aluSrcA;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       illegal;
    logic       immCare;
    logic       aluCare;
    logic [2:0] f3;
  } ctrlT;

  // One table vector: D inputs, E-stage flags {Zero,Lt,Ltu}, expectations
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] flags;
    logic       expIll;
    logic       immChk;
    logic [2:0] expImm;
    logic       expRw;
    logic       aluChk;
    logic [3:0] expAlu;
    logic       expPc;
    logic       expTgt;
    string      name;
  } vecT;

  // A bubble: nothing written, no redirect, every E field zero
  function automatic ctrlT bubble();
    ctrlT c;
    c = '{default: '0};
    c.aluCare = 1'b1;
    return c;
  endfunction

  // Reference decode: what each RV32I instruction class needs from control
  function automatic ctrlT modelDecode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    ctrlT c;
    logic [3:0] aluByF3 [8];
    aluByF3 = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    c = bubble();
    c.f3 = f3;
    c.immCare = 1'b1;
    case (op)
      OP_LOAD:  begin c.regWrite = 1; c.resultSrc = 2'b01; c.aluSrc = 1; c.imm = 3'b000; end
      OP_STORE: begin c.memWrite = 1; c.aluSrc = 1; c.imm = 3'b001; end
      OP_R: begin
        c.regWrite = 1; c.immCare = 0; c.alu = aluByF3[f3];
        if (f3 == 3'd0 && f7) c.alu = 4'd1;
        if (f3 == 3'd5 && f7) c.alu = 4'd9;
      end
      OP_IALU: begin
        c.regWrite = 1; c.aluSrc = 1; c.imm = 3'b000; c.alu = aluByF3[f3];
        if (f3 == 3'd5 && f7) c.alu = 4'd9;
      end
      OP_BRANCH: begin
        c.imm = 3'b010;
        if (f3 == 3'd2 || f3 == 3'd3) begin c.illegal = 1; c.aluCare = 0; end
        else begin c.branch = 1; c.alu = 4'd1; end
      end
      OP_JAL:   begin c.regWrite = 1; c.resultSrc = 2'b10; c.jump = 1; c.imm = 3'b011; c.aluCare = 0; end
      OP_JALR:  begin c.regWrite = 1; c.resultSrc = 2'b10; c.jump = 1; c.jalr = 1; c.aluSrc = 1; c.imm = 3'b000; end
      OP_LUI:   begin c.regWrite = 1; c.resultSrc = 2'b11; c.imm = 3'b100; c.aluCare = 0; end
      OP_AUIPC: begin c.regWrite = 1; c.aluSrc = 1; c.aluSrcA = 1; c.imm = 3'b100; end
      default:  begin c.illegal = 1; c.immCare = 0; c.aluCare = 0; end
    endcase
    return c;
  endfunction

  // Branch relation computed directly on the operand values
  function automatic logic branchRelation(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vecT mkVec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [2:0] flags, input logic expIll, input logic immChk,
                                input logic [2:0] expImm, input logic expRw, input logic aluChk,
                                input logic [3:0] expAlu, input logic expPc, input logic expTgt,
                                input string name);
    vecT v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.flags = flags; v.expIll = expIll; v.immChk = immChk;
    v.expImm = expImm; v.expRw = expRw; v.aluChk = aluChk; v.expAlu = expAlu;
    v.expPc = expPc; v.expTgt = expTgt; v.name = name;
    return v;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive the Decode-stage inputs and the flush request
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic flush);
    opD = op; funct3D = f3; funct7b5D = f7; FlushE = flush;
  endtask

  // Advance one clock and land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed away from any clock edge
  task automatic doReset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic setOperands(input logic [31:0] a, input logic [31:0] b);
    ZeroE = (a == b);
    LtE   = ($signed(a) < $signed(b));
    LtuE  = (a < b);
  endtask

  vecT  vecs[$];
  ctrlT issued[$];

  // Main test sequence
  initial begin
    logic [5:0] sweepExp [3];
    logic [2:0] sweepF3 [6];
    logic [2:0] sweepFlags [3];
    logic [6:0] opPool [9];

    reset_n = 1'b0;
    applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0);
    {ZeroE, LtE, LtuE} = 3'b000;

    // Reset state: jal in D must not reach any stage while reset is held
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_RegWriteE", RegWriteE, 0);
    checkOutput("rst_RegWriteM", RegWriteM, 0);
    checkOutput("rst_RegWriteW", RegWriteW, 0);
    checkOutput("rst_MemWriteM", MemWriteM, 0);
    checkOutput("rst_ResultSrcW", ResultSrcW, 0);
    checkOutput("rst_PCSrcE", PCSrcE, 0);
    checkOutput("rst_ALUControlE", ALUControlE, 0);
    checkOutput("rst_ResultSrcE0", ResultSrcE0, 0);
    checkOutput("rst_ImmSrcD", ImmSrcD, 3'b011);
    reset_n = 1'b1;

    // Vector table: decode, E-stage ALU op and branch/jump resolution
    vecs.push_back(mkVec(OP_R, 3'd0, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd0, 0, 0, "add"));
    vecs.push_back(mkVec(OP_R, 3'd0, 1, 3'b000, 0, 0, 3'b000, 1, 1, 4'd1, 0, 0, "sub"));
    vecs.push_back(mkVec(OP_R, 3'd1, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd7, 0, 0, "sll"));
    vecs.push_back(mkVec(OP_R, 3'd2, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd5, 0, 0, "slt"));
    vecs.push_back(mkVec(OP_R, 3'd3, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd6, 0, 0, "sltu"));
    vecs.push_back(mkVec(OP_R, 3'd4, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd4, 0, 0, "xor"));
    vecs.push_back(mkVec(OP_R, 3'd5, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd8, 0, 0, "srl"));
    vecs.push_back(mkVec(OP_R, 3'd5, 1, 3'b000, 0, 0, 3'b000, 1, 1, 4'd9, 0, 0, "sra"));
    vecs.push_back(mkVec(OP_R, 3'd6, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd3, 0, 0, "or"));
    vecs.push_back(mkVec(OP_R, 3'd7, 0, 3'b000, 0, 0, 3'b000, 1, 1, 4'd2, 0, 0, "and"));
    vecs.push_back(mkVec(OP_IALU, 3'd0, 1, 3'b000, 0, 1, 3'b000, 1, 1, 4'd0, 0, 0, "addi_f7"));
    vecs.push_back(mkVec(OP_IALU, 3'd5, 1, 3'b000, 0, 1, 3'b000, 1, 1, 4'd9, 0, 0, "srai"));
    vecs.push_back(mkVec(OP_IALU, 3'd5, 0, 3'b000, 0, 1, 3'b000, 1, 1, 4'd8, 0, 0, "srli"));
    vecs.push_back(mkVec(OP_LOAD, 3'd2, 0, 3'b000, 0, 1, 3'b000, 1, 1, 4'd0, 0, 0, "lw"));
    vecs.push_back(mkVec(OP_STORE, 3'd2, 0, 3'b000, 0, 1, 3'b001, 0, 1, 4'd0, 0, 0, "sw"));
    vecs.push_back(mkVec(OP_LUI, 3'd0, 0, 3'b000, 0, 1, 3'b100, 1, 0, 4'd0, 0, 0, "lui"));
    vecs.push_back(mkVec(OP_AUIPC, 3'd0, 0, 3'b000, 0, 1, 3'b100, 1, 1, 4'd0, 0, 0, "auipc"));
    vecs.push_back(mkVec(OP_JAL, 3'd0, 0, 3'b000, 0, 1, 3'b011, 1, 0, 4'd0, 1, 0, "jal"));
    vecs.push_back(mkVec(OP_JALR, 3'd0, 0, 3'b000, 0, 1, 3'b000, 1, 1, 4'd0, 1, 1, "jalr"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd0, 0, 3'b100, 0, 1, 3'b010, 0, 1, 4'd1, 1, 0, "beq_t"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd1, 0, 3'b100, 0, 1, 3'b010, 0, 1, 4'd1, 0, 0, "bne_nt"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd4, 0, 3'b010, 0, 1, 3'b010, 0, 1, 4'd1, 1, 0, "blt_t"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd7, 0, 3'b001, 0, 1, 3'b010, 0, 1, 4'd1, 0, 0, "bgeu_nt"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd6, 0, 3'b100, 0, 1, 3'b010, 0, 1, 4'd1, 0, 0, "bltu_nt"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd2, 0, 3'b111, 1, 1, 3'b010, 0, 0, 4'd0, 0, 0, "br_f3_010"));
    vecs.push_back(mkVec(OP_BRANCH, 3'd3, 0, 3'b111, 1, 1, 3'b010, 0, 0, 4'd0, 0, 0, "br_f3_011"));
    vecs.push_back(mkVec(OP_BAD, 3'd0, 0, 3'b111, 1, 0, 3'b000, 0, 0, 4'd0, 0, 0, "op_7f"));
    vecs.push_back(mkVec(7'b0000000, 3'd0, 0, 3'b111, 1, 0, 3'b000, 0, 0, 4'd0, 0, 0, "op_00"));

    tick();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b0);
      #1;
      checkOutput({vecs[i].name, "_IllegalD"}, IllegalD, vecs[i].expIll);
      if (vecs[i].immChk) checkOutput({vecs[i].name, "_ImmSrcD"}, ImmSrcD, vecs[i].expImm);
      tick();
      {ZeroE, LtE, LtuE} = vecs[i].flags;
      #1;
      checkOutput({vecs[i].name, "_RegWriteE"}, RegWriteE, vecs[i].expRw);
      if (vecs[i].aluChk) checkOutput({vecs[i].name, "_ALUControlE"}, ALUControlE, vecs[i].expAlu);
      checkOutput({vecs[i].name, "_PCSrcE"}, PCSrcE, vecs[i].expPc);
      checkOutput({vecs[i].name, "_PCTargetSrcE"}, PCTargetSrcE, vecs[i].expTgt);
    end

    // Branch sweep: six conditions against the three single-flag patterns.
    // Bit i of sweepExp[p] is the outcome for sweepF3[i] under sweepFlags[p].
    sweepF3    = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    sweepFlags = '{3'b100, 3'b010, 3'b001};
    sweepExp[0] = 6'b101001;
    sweepExp[1] = 6'b100110;
    sweepExp[2] = 6'b011010;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) begin
        applyStimulus(OP_BRANCH, sweepF3[i], 1'b0, 1'b0);
        tick();
        {ZeroE, LtE, LtuE} = sweepFlags[p];
        #1;
        checkOutput($sformatf("sweep_f3_%0d_flags_%03b", sweepF3[i], sweepFlags[p]), PCSrcE, sweepExp[p][i]);
      end
    end

    // Mid-stream asynchronous reset, then first decode after release
    doReset();
    applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("pre_rst_PCSrcE", PCSrcE, 1);
    checkOutput("pre_rst_RegWriteW", RegWriteW, 1);
    applyStimulus(OP_BAD, 3'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_PCSrcE", PCSrcE, 0);
    checkOutput("async_rst_RegWriteE", RegWriteE, 0);
    checkOutput("async_rst_RegWriteM", RegWriteM, 0);
    checkOutput("async_rst_RegWriteW", RegWriteW, 0);
    checkOutput("async_rst_ResultSrcW", ResultSrcW, 0);
    checkOutput("rst_IllegalD_comb", IllegalD, 1);
    tick();
    checkOutput("rst_hold_RegWriteE", RegWriteE, 0);
    reset_n = 1'b1;
    applyStimulus(OP_R, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("post_rst_e1_RegWriteE", RegWriteE, 1);
    checkOutput("post_rst_e1_ALUControlE", ALUControlE, 0);
    checkOutput("post_rst_e1_RegWriteM", RegWriteM, 0);
    applyStimulus(OP_STORE, 3'd2, 1'b0, 1'b0);
    tick();
    checkOutput("post_rst_e2_RegWriteM", RegWriteM, 1);
    tick();
    checkOutput("post_rst_e3_RegWriteW", RegWriteW, 1);
    checkOutput("post_rst_e3_ResultSrcW", ResultSrcW, 0);

    // Load followed by a flushed slot
    doReset();
    applyStimulus(OP_LOAD, 3'd2, 1'b0, 1'b0);
    tick();
    checkOutput("ld_ResultSrcE0", ResultSrcE0, 1);
    applyStimulus(OP_R, 3'd0, 1'b0, 1'b1);
    tick();
    checkOutput("flush_ResultSrcE0", ResultSrcE0, 0);
    checkOutput("flush_RegWriteE", RegWriteE, 0);
    checkOutput("ld_RegWriteM", RegWriteM, 1);
    applyStimulus(OP_R, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("flush_slot_RegWriteM", RegWriteM, 0);
    checkOutput("ld_RegWriteW", RegWriteW, 1);
    checkOutput("ld_ResultSrcW", ResultSrcW, 2'b01);
    tick();
    checkOutput("flush_slot_RegWriteW", RegWriteW, 0);

    // Illegal opcode drains without writes; the store ahead of it still writes
    applyStimulus(OP_STORE, 3'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(OP_BAD, 3'd0, 1'b0, 1'b0);
    #1;
    checkOutput("ill_IllegalD", IllegalD, 1);
    tick();
    checkOutput("ill_e_RegWriteE", RegWriteE, 0);
    checkOutput("st_MemWriteM", MemWriteM, 1);
    tick();
    checkOutput("ill_m_MemWriteM", MemWriteM, 0);
    checkOutput("ill_m_RegWriteM", RegWriteM, 0);
    tick();
    checkOutput("ill_w_RegWriteW", RegWriteW, 0);
    checkOutput("ill_w_MemWriteM", MemWriteM, 0);

    // JALR through W, then JAL target select
    applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("jalr_PCSrcE", PCSrcE, 1);
    checkOutput("jalr_PCTargetSrcE", PCTargetSrcE, 1);
    applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("jal_PCTargetSrcE", PCTargetSrcE, 0);
    checkOutput("jal_PCSrcE", PCSrcE, 1);
    applyStimulus(OP_R, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("jalr_ResultSrcW", ResultSrcW, 2'b10);
    checkOutput("jalr_RegWriteW", RegWriteW, 1);

    // Randomized traffic against the queue model: entry k enters E at edge k,
    // so E, M and W see the last, second-last and third-last entries.
    opPool = '{OP_LOAD, OP_STORE, OP_R, OP_IALU, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    doReset();
    repeat (3) issued.push_back(bubble());
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, fl;
      logic [31:0] a, b;
      ctrlT        d, e, m, w;
      int          n;
      op = ($urandom_range(0, 9) == 9) ? 7'($urandom_range(0, 127)) : opPool[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 6) == 0);
      applyStimulus(op, f3, f7, fl);
      #1;
      d = modelDecode(op, f3, f7);
      checkOutput("rnd_IllegalD", IllegalD, d.illegal);
      if (d.immCare) checkOutput("rnd_ImmSrcD", ImmSrcD, d.imm);
      tick();
      issued.push_back(fl ? bubble() : d);
      if (issued.size() > 4) void'(issued.pop_front());
      n = issued.size();
      e = issued[n-1];
      m = issued[n-2];
      w = issued[n-3];
      checkOutput("rnd_RegWriteE", RegWriteE, e.regWrite);
      checkOutput("rnd_ResultSrcE0", ResultSrcE0, e.resultSrc[0]);
      if (e.aluCare) begin
        checkOutput("rnd_ALUControlE", ALUControlE, e.alu);
        checkOutput("rnd_ALUSrcE", ALUSrcE, e.aluSrc);
        checkOutput("rnd_ALUSrcAE", ALUSrcAE, e.aluSrcA);
      end
      checkOutput("rnd_RegWriteM", RegWriteM, m.regWrite);
      checkOutput("rnd_MemWriteM", MemWriteM, m.memWrite);
      checkOutput("rnd_RegWriteW", RegWriteW, w.regWrite);
      checkOutput("rnd_ResultSrcW", ResultSrcW, w.resultSrc);
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      setOperands(a, b);
      #1;
      checkOutput("rnd_PCSrcE", PCSrcE, e.jump | (e.branch & branchRelation(e.f3, a, b)));
      checkOutput("rnd_PCTargetSrcE", PCTargetSrcE, e.jump & e.jalr);
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // Counters: 17 taken redirects wrap a 4-bit counter to 1; 3 flushes give 3
    doReset();
    applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0);
    repeat (18) tick();
    checkOutput("cnt_BranchTakenCnt_wrap", branchTakenCnt, 1);
    doReset();
    applyStimulus(OP_R, 3'd0, 1'b0, 1'b1);
    repeat (3) tick();
    applyStimulus(OP_R, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("cnt_FlushCnt", flushCnt, 3);
    checkOutput("cnt_BranchTakenCnt_clr", branchTakenCnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
